mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be: width, 32, data/address width (only 32 is supported).
REQ-002 Ports SHALL be:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- req_i  in  1  access request from the CPU side.
- wr_i  in  1  1 = store, 0 = load.
- size_i  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- sign_i  in  1  1 = sign-extend loads, 0 = zero-extend loads.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data; byte/half data is in the low bits.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  misaligned or illegal access; valid with done_o.
- rdata_o  out  32  load result.
- mem_addr_o  out  32  word-aligned memory address.
- mem_cs_o  out  1  memory read select.
- mem_we_o  out  1  memory write enable.
- mem_data_o  out  32  memory write data.
- mem_data_i  in  32  memory read data.

Function
REQ-003 The block SHALL be the initiator for a word memory with these properties:
- a read is issued by holding cs high for one cycle; the read data is registered on that edge and held stable for the following cycle;
- a write is issued by holding we high with cs low; it takes one cycle.
REQ-004 The FSM SHALL have the states IDLE, RD, RCAP, WR and DONE.
REQ-005 In IDLE with req_i=1, the block SHALL capture wr_i, size_i, sign_i, addr_i and wdata_i on the clock edge; req_i SHALL be ignored in every other state.
REQ-006 Misalignment SHALL be detected as follows:
- misaligned = (size 01 and addr[0]=1) or (size 10 and addr[1:0]≠0) or size 11;
- a misaligned access SHALL go IDLE→DONE with err_o=1;
- no cs or we SHALL be issued for a misaligned access.
REQ-007 State sequences SHALL be:
- load: IDLE→RD→RCAP→DONE→IDLE;
- word store: IDLE→WR→DONE→IDLE;
- byte/half store: IDLE→RD→RCAP→WR→DONE→IDLE (read-modify-write).
REQ-008 Memory-side strobes SHALL be decoded from the state:
- mem_cs_o = 1 only in RD;
- mem_we_o = 1 only in WR;
- mem_cs_o and mem_we_o SHALL never be high together.
REQ-009 mem_addr_o SHALL equal {captured addr[31:2], 2'b00} from RD or WR entry through DONE, and 0 in IDLE.
REQ-010 Byte lanes SHALL be little-endian:
- byte k occupies bits [8k+7:8k], where k = addr[1:0];
- the half occupies bits [16h+15:16h], where h = addr[1].
REQ-011 At the end of RCAP, the block SHALL sample mem_data_i:
- load: extract the lane, extend it per sign_i, and register the result into rdata_o;
- store: replace the addressed lane with the low bits of wdata_i, keeping the other lanes, and register the result into mem_data_o.
REQ-012 For a word store, mem_data_o SHALL equal wdata_i in WR; mem_data_o is don't-care outside WR.
REQ-013 done_o SHALL be 1 only in DONE, and err_o SHALL be valid in the same cycle.
REQ-014 rdata_o SHALL hold its value until the next load completes; stores and errors SHALL NOT change it.
REQ-015 Latency, counted from the acceptance edge, SHALL be:
- done_o high in cycle 1 for an error;
- done_o high in cycle 2 for a word store;
- done_o high in cycle 3 for a load;
- done_o high in cycle 4 for a byte/half store.
REQ-016 Throughput SHALL be at most one access per (latency + 1) cycles; a new request can be accepted only in IDLE.

Reset
REQ-017 rst_n_i low SHALL immediately force the following, independent of clk_i:
- state = IDLE;
- busy_o, done_o, err_o, mem_cs_o and mem_we_o = 0;
- rdata_o, mem_addr_o and mem_data_o = 0.
REQ-018 A reset asserted mid-operation SHALL abandon the access; any pending write SHALL NOT be issued after rst_n_i rises.
REQ-019 After rst_n_i rises, the first request SHALL be accepted on the first edge at which it is sampled high.

Verification (memory word 0x40 preloaded with 0x8899AABB)
REQ-020 Signed byte load at 0x41 -> exactly one mem_cs_o pulse with mem_addr_o=0x40; done_o in cycle 3; rdata_o=0xFFFFFFAA; err_o=0.
REQ-021 Unsigned half load at 0x42 -> rdata_o=0x00008899; a signed half load at 0x40 -> rdata_o=0xFFFFAABB.
REQ-022 Byte store of 0x5C to 0x43 -> mem_cs_o in cycle 1, then mem_we_o in cycle 3 with mem_data_o=0x5C99AABB; done_o in cycle 4; a reload of the word returns 0x5C99AABB.
REQ-023 Word store of 0xDEADBEEF to 0x44 -> no mem_cs_o; one mem_we_o cycle with mem_addr_o=0x44 and mem_data_o=0xDEADBEEF; done_o in cycle 2.
REQ-024 Half load at 0x41, and any access with size_i=11 -> done_o and err_o=1 in cycle 1; no mem_cs_o or mem_we_o; rdata_o unchanged.
REQ-025 rst_n_i pulsed low during RCAP of a byte store -> all outputs 0 immediately; no mem_we_o afterwards; memory unchanged; the next word load completes normally; req_i asserted while busy_o=1 causes no extra access.

Source files
------------

// File: rtl/mem_access_unit.sv
// Purpose : CPU load/store initiator for a single-port word memory.
//           Handles byte/half/word accesses, performs sub-word stores as a
//           read-modify-write, and flags misaligned or illegal-size requests.
// Latency : done_o in cycle 1 (error), 2 (word store), 3 (load),
//           4 (byte/half store), counted from the accepting edge.
// Backpr. : a request is taken only in IDLE; req_i is ignored while busy_o=1.
// Ports   : clk_i/rst_n_i   clock, async active-low reset
//           req_i..wdata_i  CPU-side request (captured on acceptance)
//           busy_o, done_o, err_o, rdata_o  CPU-side status/result
//           mem_*           memory-side address, strobes and data
module mem_access_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req_i,
    input  logic             wr_i,
    input  logic [1:0]       size_i,
    input  logic             sign_i,
    input  logic [WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic             mem_cs_o,
    output logic             mem_we_o,
    output logic [WIDTH-1:0] mem_data_o,
    input  logic [WIDTH-1:0] mem_data_i
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RCAP = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             wr_q;
    logic [1:0]       size_q;
    logic             sign_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic             err_q;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] mem_data_q;

    logic             accept;
    logic             misaligned;
    logic             word_store;
    logic [4:0]       lane_shamt;
    logic [WIDTH-1:0] rd_shifted;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] lane_mask;
    logic [WIDTH-1:0] merged;

    assign accept     = (state_q == IDLE) && req_i;
    assign misaligned = (size_i == 2'b11)
                     || ((size_i == 2'b01) && addr_i[0])
                     || ((size_i == 2'b10) && (addr_i[1:0] != 2'b00));
    // Full-word stores skip the read phase; nothing else needs the old word.
    assign word_store = wr_i && (size_i == 2'b10);

    // Lane position in bits; for an aligned half addr_q[0] is 0, so this is 0 or 16.
    assign lane_shamt = {addr_q[1:0], 3'b000};
    assign rd_shifted = mem_data_i >> lane_shamt;

    always_comb begin
        load_val  = mem_data_i;
        lane_mask = '0;
        case (size_q)
            2'b00: begin
                load_val  = {{24{sign_q & rd_shifted[7]}}, rd_shifted[7:0]};
                lane_mask = 32'h0000_00FF << lane_shamt;
            end
            2'b01: begin
                load_val  = {{16{sign_q & rd_shifted[15]}}, rd_shifted[15:0]};
                lane_mask = 32'h0000_FFFF << lane_shamt;
            end
            default: begin
                load_val  = mem_data_i;
                lane_mask = '1;
            end
        endcase
    end

    // Read-modify-write: addressed lane comes from the store data, others from memory.
    assign merged = (mem_data_i & ~lane_mask) | ((wdata_q << lane_shamt) & lane_mask);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        busy_o   = 1'b1;
        done_o   = 1'b0;
        err_o    = 1'b0;
        mem_cs_o = 1'b0;
        mem_we_o = 1'b0;
        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (req_i) begin
                    if (misaligned) begin
                        state_d = DONE;
                    end else if (word_store) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                mem_cs_o = 1'b1;
                state_d  = RCAP;
            end
            RCAP: begin
                state_d = wr_q ? WR : DONE;
            end
            WR: begin
                mem_we_o = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                err_o   = err_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q       <= 1'b0;
            size_q     <= 2'b00;
            sign_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            mem_data_q <= '0;
        end else begin
            if (accept) begin
                wr_q    <= wr_i;
                size_q  <= size_i;
                sign_q  <= sign_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                err_q   <= misaligned;
                if (word_store && !misaligned) begin
                    mem_data_q <= wdata_i;
                end
            end
            // Memory data is valid during RCAP; sample it on the way out.
            if (state_q == RCAP) begin
                if (wr_q) begin
                    mem_data_q <= merged;
                end else begin
                    rdata_q <= load_val;
                end
            end
        end
    end

    assign rdata_o    = rdata_q;
    assign mem_data_o = mem_data_q;
    assign mem_addr_o = (state_q == IDLE) ? '0 : {addr_q[WIDTH-1:2], 2'b00};

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, reset-abort sequence, random
// accesses against a byte-array reference model.
// Memory model: 64 words, read data registered on cs and held one cycle.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err, mem_cs, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdat;
    logic [31:0] mem_rd;

    logic [31:0] tb_mem [64];
    logic [7:0]  ref_mem [256];
    logic [31:0] model_rdata;

    int checks = 0;
    int failures = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .wr_i(wr), .size_i(size),
        .sign_i(sign), .addr_i(addr), .wdata_i(wdata), .busy_o(busy),
        .done_o(done), .err_o(err), .rdata_o(rdata), .mem_addr_o(mem_addr),
        .mem_cs_o(mem_cs), .mem_we_o(mem_we), .mem_data_o(mem_wdat),
        .mem_data_i(mem_rd)
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h0101_0101) ^ 32'hA5C3_3C5A;
    endfunction

    // Environment memory: read data valid only in the cycle after cs.
    initial begin
        for (int i = 0; i < 64; i++) tb_mem[i] = init_word(i);
        tb_mem[16] = 32'h8899_AABB;
        tb_mem[18] = 32'h1122_3344;
        mem_rd = '0;
        forever begin
            @(posedge clk);
            if (mem_cs) mem_rd <= tb_mem[mem_addr[7:2]];
            else        mem_rd <= $urandom;
            if (mem_we) tb_mem[mem_addr[7:2]] <= mem_wdat;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed memory, access semantics straight from the rules.
    task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic e, output logic [31:0] rd_exp,
                         output int ncs, output int nwe, output logic [31:0] wedat);
        int n, ai, base;
        logic [31:0] v;
        e = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
        ncs = 0; nwe = 0; wedat = '0; lat = 1;
        ai = int'(a[7:0]);
        base = ai & 'hFC;
        if (!e) begin
            n = 1 << sz;
            if (!w) begin
                v = '0;
                for (int i = 0; i < n; i++) v = v | (32'(ref_mem[ai + i]) << (8 * i));
                if (sg && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
                model_rdata = v;
                lat = 3; ncs = 1;
            end else begin
                for (int i = 0; i < n; i++) ref_mem[ai + i] = wd[8 * i +: 8];
                for (int i = 0; i < 4; i++) wedat = wedat | (32'(ref_mem[base + i]) << (8 * i));
                nwe = 1;
                lat = (n == 4) ? 2 : 4;
                ncs = (n == 4) ? 0 : 1;
            end
        end
        rd_exp = model_rdata;
    endtask

    task automatic do_access(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd, input bit hold_req,
                             output int lat, output logic e, output int ncs, output int nwe,
                             output logic [31:0] wedat, output logic [31:0] weaddr,
                             output logic [31:0] csaddr);
        @(negedge clk);
        req = 1'b1; wr = w; size = sz; sign = sg; addr = a; wdata = wd;
        @(posedge clk);
        #1;
        if (!hold_req) begin
            req = 1'b0;
            wdata = $urandom;
            addr = $urandom;
        end
        lat = 0; e = 1'b0; ncs = 0; nwe = 0; wedat = '0; weaddr = '0; csaddr = '0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (mem_cs && mem_we) overlap++;
            if (mem_cs) begin ncs++; csaddr = mem_addr; end
            if (mem_we) begin nwe++; wedat = mem_wdat; weaddr = mem_addr; end
            if (done) begin lat = c; e = err; end
        end
        req = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic w, input logic [1:0] sz,
                             input logic sg, input logic [31:0] a, input logic [31:0] wd,
                             input int xlat, input logic xerr, input logic [31:0] xrd,
                             input int xcs, input int xwe, input logic [31:0] xwed,
                             input bit hold_req);
        int lat, ncs, nwe;
        logic e;
        logic [31:0] wedat, weaddr, csaddr;
        do_access(w, sz, sg, a, wd, hold_req, lat, e, ncs, nwe, wedat, weaddr, csaddr);
        chk({tag, " latency"}, 32'(lat), 32'(xlat));
        chk({tag, " err"}, {31'd0, e}, {31'd0, xerr});
        chk({tag, " rdata"}, rdata, xrd);
        chk({tag, " cs_count"}, 32'(ncs), 32'(xcs));
        chk({tag, " we_count"}, 32'(nwe), 32'(xwe));
        if (xwe > 0) begin
            chk({tag, " we_data"}, wedat, xwed);
            chk({tag, " we_addr"}, weaddr, a & 32'hFFFF_FFFC);
        end
        if (ncs > 0) chk({tag, " cs_addr"}, csaddr, a & 32'hFFFF_FFFC);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        int          lat;
        logic        e;
        logic [31:0] rd;
        int          ncs;
        int          nwe;
        logic [31:0] wed;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int lat, ncs, nwe, stray;
        logic e;
        logic [31:0] rd_exp, wedat;
        logic w, sg;
        logic [1:0] sz;
        logic [31:0] a, wd;

        tbl[0] = '{1'b0, 2'd0, 1'b1, 32'h41, 32'h0,        3, 1'b0, 32'hFFFF_FFAA, 1, 0, 32'h0};
        tbl[1] = '{1'b0, 2'd1, 1'b0, 32'h42, 32'h0,        3, 1'b0, 32'h0000_8899, 1, 0, 32'h0};
        tbl[2] = '{1'b0, 2'd1, 1'b1, 32'h40, 32'h0,        3, 1'b0, 32'hFFFF_AABB, 1, 0, 32'h0};
        tbl[3] = '{1'b1, 2'd0, 1'b0, 32'h43, 32'hFFFF_FF5C, 4, 1'b0, 32'hFFFF_AABB, 1, 1, 32'h5C99_AABB};
        tbl[4] = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        3, 1'b0, 32'h5C99_AABB, 1, 0, 32'h0};
        tbl[5] = '{1'b1, 2'd2, 1'b0, 32'h44, 32'hDEAD_BEEF, 2, 1'b0, 32'h5C99_AABB, 0, 1, 32'hDEAD_BEEF};
        tbl[6] = '{1'b0, 2'd1, 1'b0, 32'h41, 32'h0,        1, 1'b1, 32'h5C99_AABB, 0, 0, 32'h0};
        tbl[7] = '{1'b1, 2'd3, 1'b0, 32'h40, 32'h1234_5678, 1, 1'b1, 32'h5C99_AABB, 0, 0, 32'h0};
        tbl[8] = '{1'b0, 2'd2, 1'b1, 32'h44, 32'h0,        3, 1'b0, 32'hDEAD_BEEF, 1, 0, 32'h0};

        #1;
        for (int i = 0; i < 64; i++)
            for (int b = 0; b < 4; b++) ref_mem[4 * i + b] = tb_mem[i][8 * b +: 8];
        model_rdata = '0;

        // Reset state.
        #2;
        chk("reset ctrl", {27'd0, busy, done, err, mem_cs, mem_we}, 32'd0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_data", mem_wdat, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table; the reference model is kept in step with memory.
        for (int i = 0; i < 9; i++) begin
            model(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, lat, e, rd_exp, ncs, nwe, wedat);
            run_check($sformatf("vec%0d", i), tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd,
                      tbl[i].lat, tbl[i].e, tbl[i].rd, tbl[i].ncs, tbl[i].nwe, tbl[i].wed, 1'b0);
        end
        chk("reload mem40", tb_mem[16], 32'h5C99_AABB);

        // Reset pulsed during RCAP of a byte store.
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'd0; sign = 1'b0; addr = 32'h49; wdata = 32'hA5;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        chk("abort RD cs", {31'd0, mem_cs}, 32'd1);
        @(negedge clk);
        chk("abort RCAP busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort ctrl", {27'd0, busy, done, err, mem_cs, mem_we}, 32'd0);
        chk("abort rdata", rdata, 32'd0);
        chk("abort mem_addr", mem_addr, 32'd0);
        chk("abort mem_data", mem_wdat, 32'd0);
        model_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_we || busy) stray++;
        end
        chk("abort no write", 32'(stray), 32'd0);
        chk("abort mem48", tb_mem[18], 32'h1122_3344);

        // Word load with req_i held high while busy.
        model(1'b0, 2'd2, 1'b0, 32'h48, 32'h0, lat, e, rd_exp, ncs, nwe, wedat);
        run_check("held_req", 1'b0, 2'd2, 1'b0, 32'h48, 32'h0, 3, 1'b0, 32'h1122_3344, 1, 0, 32'h0, 1'b1);
        @(negedge clk);
        chk("held_req idle after", {31'd0, busy}, 32'd0);

        // Random accesses against the reference model.
        for (int n = 0; n < 300; n++) begin
            w  = 1'($urandom);
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom);
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            wd = $urandom;
            model(w, sz, sg, a, wd, lat, e, rd_exp, ncs, nwe, wedat);
            run_check($sformatf("rnd%0d", n), w, sz, sg, a, wd, lat, e, rd_exp, ncs, nwe, wedat, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            logic [31:0] exp_w;
            exp_w = {ref_mem[4 * i + 3], ref_mem[4 * i + 2], ref_mem[4 * i + 1], ref_mem[4 * i]};
            chk($sformatf("final mem%0d", i), tb_mem[i], exp_w);
        end
        chk("cs_we overlap", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
